// File: rtl/hack_pkg.sv
// Shared types and constants for the HACK boot sequencer.
package hack_pkg;

    localparam int unsigned HACK_WORD_W = 16;
    localparam int unsigned HACK_BYTE_W = 8;

    typedef enum logic [3:0] {
        HDR_HI,
        HDR_LO,
        DAT_HI,
        DAT_LO,
        WRITE,
        CS_HI,
        CS_LO,
        RUN,
        ERROR
    } boot_state_t;

    // States that hold rx_ready high and consume one byte per step.
    function automatic logic is_rx_state(input boot_state_t s);
        logic r;
        case (s)
            HDR_HI, HDR_LO, DAT_HI, DAT_LO, CS_HI, CS_LO: r = 1'b1;
            default:                                      r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hack_timeout_ctr.sv
// Inter-byte idle watchdog: expired rises after TIMEOUT-1 consecutive enabled
// cycles without clr, so the owner reacts on the TIMEOUT-th edge.
module hack_timeout_ctr #(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count   <= '0;
            expired <= 1'b0;
        end else if (en && !expired) begin
            count   <= count + CNT_W'(1);
            expired <= ((count + CNT_W'(1)) == LAST);
        end
    end

endmodule

// File: rtl/hack_boot_ctrl.sv
// Boot sequencer: loads a length-prefixed, checksummed byte image into the
// instruction ROM while holding the CPU in reset, then releases it.
module hack_boot_ctrl
    import hack_pkg::*;
#(
    parameter int unsigned ADDR_W    = 15,
    parameter int unsigned ROM_DEPTH = 32768,
    parameter int unsigned TIMEOUT   = 1000000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [HACK_BYTE_W-1:0] rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    input  logic                   reload,
    output logic                   rom_wr_en,
    output logic [ADDR_W-1:0]      rom_wr_addr,
    output logic [HACK_WORD_W-1:0] rom_wr_data,
    output logic                   cpu_reset,
    output logic                   boot_done,
    output logic                   boot_err
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned CMP_W = ((CNT_W > HACK_WORD_W) ? CNT_W : HACK_WORD_W) + 1;

    boot_state_t            state_q, state_d;
    logic [HACK_BYTE_W-1:0] hi_q, hi_d;
    logic [HACK_WORD_W-1:0] n_q, n_d;
    logic [HACK_WORD_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [HACK_WORD_W-1:0] acc_q, acc_d;

    logic                   wr_en_d;
    logic [ADDR_W-1:0]      wr_addr_d;
    logic [HACK_WORD_W-1:0] wr_data_d;
    logic                   cpu_reset_d;
    logic                   boot_done_d;
    logic                   boot_err_d;

    logic                   xfer;
    logic                   to_en;
    logic                   to_clr;
    logic                   to_expired;
    logic [HACK_WORD_W-1:0] rx_word;
    logic                   hdr_ok;
    logic                   last_word;

    assign rx_ready  = is_rx_state(state_q);
    assign xfer      = rx_valid & rx_ready;
    assign rx_word   = {hi_q, rx_data};
    assign hdr_ok    = (rx_word != '0) && (CMP_W'(rx_word) <= CMP_W'(ROM_DEPTH));
    assign last_word = ((CMP_W'(cnt_q) + CMP_W'(1)) == CMP_W'(n_q));

    // Watchdog runs only while waiting for a byte mid-image.
    assign to_en  = rx_ready && (state_q != HDR_HI);
    assign to_clr = xfer | reload | ~to_en;

    hack_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

    // State, datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= HDR_HI;
            hi_q        <= '0;
            n_q         <= '0;
            word_q      <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            rom_wr_en   <= 1'b0;
            rom_wr_addr <= '0;
            rom_wr_data <= '0;
            cpu_reset   <= 1'b1;
            boot_done   <= 1'b0;
            boot_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            n_q         <= n_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            rom_wr_en   <= wr_en_d;
            rom_wr_addr <= wr_addr_d;
            rom_wr_data <= wr_data_d;
            cpu_reset   <= cpu_reset_d;
            boot_done   <= boot_done_d;
            boot_err    <= boot_err_d;
        end
    end

    // Next state; write strobe/address/data are set up so they appear during WRITE.
    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        n_d         = n_q;
        word_d      = word_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = rom_wr_addr;
        wr_data_d   = rom_wr_data;

        case (state_q)
            HDR_HI: begin
                if (xfer) begin
                    hi_d    = rx_data;
                    state_d = HDR_LO;
                end
            end
            HDR_LO: begin
                if (xfer) begin
                    n_d     = rx_word;
                    state_d = hdr_ok ? DAT_HI : ERROR;
                end else if (to_expired) begin
                    state_d = ERROR;
                end
            end
            DAT_HI: begin
                if (xfer) begin
                    hi_d    = rx_data;
                    state_d = DAT_LO;
                end else if (to_expired) begin
                    state_d = ERROR;
                end
            end
            DAT_LO: begin
                if (xfer) begin
                    word_d    = rx_word;
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[ADDR_W-1:0];
                    wr_data_d = rx_word;
                    state_d   = WRITE;
                end else if (to_expired) begin
                    state_d = ERROR;
                end
            end
            WRITE: begin
                acc_d   = acc_q + word_q;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = last_word ? CS_HI : DAT_HI;
            end
            CS_HI: begin
                if (xfer) begin
                    hi_d    = rx_data;
                    state_d = CS_LO;
                end else if (to_expired) begin
                    state_d = ERROR;
                end
            end
            CS_LO: begin
                if (xfer) begin
                    state_d = (rx_word == acc_q) ? RUN : ERROR;
                end else if (to_expired) begin
                    state_d = ERROR;
                end
            end
            RUN:     state_d = RUN;
            ERROR:   state_d = ERROR;
            default: state_d = HDR_HI;
        endcase

        // A reload wins over any byte arriving in the same cycle.
        if (reload) begin
            state_d = HDR_HI;
            cnt_d   = '0;
            acc_d   = '0;
            wr_en_d = 1'b0;
        end

        cpu_reset_d = (state_d != RUN);
        boot_done_d = (state_d == RUN);
        boot_err_d  = (state_d == ERROR);
    end

endmodule

// File: tb/tb_hack_boot_ctrl.sv
// Self-checking bench for hack_boot_ctrl: image-level reference model plus
// directed images with literal expectations.
module tb_hack_boot_ctrl;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned TO     = 16;

    localparam int M_LOAD = 0;
    localparam int M_RUN  = 1;
    localparam int M_ERR  = 2;

    logic              clock;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              reload;
    logic              rom_wr_en;
    logic [ADDR_W-1:0] rom_wr_addr;
    logic [15:0]       rom_wr_data;
    logic              cpu_reset;
    logic              boot_done;
    logic              boot_err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    hack_boot_ctrl #(
        .ADDR_W    (ADDR_W),
        .ROM_DEPTH (DEPTH),
        .TIMEOUT   (TO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .reload      (reload),
        .rom_wr_en   (rom_wr_en),
        .rom_wr_addr (rom_wr_addr),
        .rom_wr_data (rom_wr_data),
        .cpu_reset   (cpu_reset),
        .boot_done   (boot_done),
        .boot_err    (boot_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model: interprets the accepted byte stream ----------------
    logic [7:0]        mq[$];
    int                mst = M_LOAD;
    bit                pend = 1'b0;
    int                idle = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [15:0]       m_data = '0;

    function automatic int word_at(input int i);
        return {mq[i], mq[i+1]};
    endfunction

    task automatic model_push(input logic [7:0] b);
        int total;
        int n;
        int sum;
        mq.push_back(b);
        total = mq.size();
        n = (total >= 2) ? word_at(0) : 0;
        if (total == 2) begin
            if (n == 0 || n > int'(DEPTH)) mst = M_ERR;
        end else if (total > 2 && (total % 2) == 0 && total <= 2 + 2 * n) begin
            pend   = 1'b1;
            m_addr = ADDR_W'((total - 4) / 2);
            m_data = 16'(word_at(total - 2));
        end else if (total == 2 * n + 4) begin
            sum = 0;
            for (int k = 0; k < n; k++) sum += word_at(2 + 2 * k);
            mst = (16'(sum) == 16'(word_at(total - 2))) ? M_RUN : M_ERR;
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            if (reset) begin
                mq.delete(); mst = M_LOAD; pend = 1'b0; idle = 0;
                m_addr = '0; m_data = '0;
            end else if (reload) begin
                mq.delete(); mst = M_LOAD; pend = 1'b0; idle = 0;
            end else if (pend) begin
                pend = 1'b0; idle = 0;
            end else if (mst == M_LOAD) begin
                if (rx_valid) begin
                    idle = 0;
                    model_push(rx_data);
                end else if (mq.size() != 0) begin
                    idle++;
                    if (idle >= int'(TO)) mst = M_ERR;
                end
            end
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (chk_en) begin
            cmp("rx_ready",    32'(rx_ready),    32'(mst == M_LOAD && !pend));
            cmp("rom_wr_en",   32'(rom_wr_en),   32'(pend));
            cmp("rom_wr_addr", 32'(rom_wr_addr), 32'(m_addr));
            cmp("rom_wr_data", 32'(rom_wr_data), 32'(m_data));
            cmp("cpu_reset",   32'(cpu_reset),   32'(mst != M_RUN));
            cmp("boot_done",   32'(boot_done),   32'(mst == M_RUN));
            cmp("boot_err",    32'(boot_err),    32'(mst == M_ERR));
        end
    end

    // ROM write log for literal checks.
    int log_a[$];
    int log_d[$];
    always @(negedge clock) begin
        if (chk_en && rom_wr_en) begin
            log_a.push_back(int'(rom_wr_addr));
            log_d.push_back(int'(rom_wr_data));
        end
    end

    task automatic check_log(input string name, input int idx, input int a, input int d);
        if (idx < log_a.size()) begin
            cmp({name, "_addr"}, 32'(log_a[idx]), 32'(a));
            cmp({name, "_data"}, 32'(log_d[idx]), 32'(d));
        end else begin
            cmp({name, "_present"}, 32'(log_a.size()), 32'(idx + 1));
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        while (!rx_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (!rx_ready) begin
            errors++;
            checks++;
            $display("FAIL send_timeout at %0t: rx_ready stayed 0 for byte 0x%0h", $time, b);
        end
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clock);
        #1;
        reload = 1'b0;
    endtask

    int cyc;
    int sum16;

    initial begin
        reset    = 1'b1;
        rx_data  = '0;
        rx_valid = 1'b0;
        reload   = 1'b0;
        @(posedge clock);
        #1;
        chk_en = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cmp("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        cmp("rst_rx_ready",  32'(rx_ready),  32'd1);
        cmp("rst_boot_done", 32'(boot_done), 32'd0);

        // 1: three-word image, good checksum
        log_a.delete(); log_d.delete();
        send_word(16'h0003); send_word(16'h0001); send_word(16'h0002);
        send_word(16'h0003); send_word(16'h0006);
        cmp("t1_cpu_reset", 32'(cpu_reset), 32'd0);
        cmp("t1_boot_done", 32'(boot_done), 32'd1);
        cmp("t1_nwrites",   32'(log_a.size()), 32'd3);
        check_log("t1_w0", 0, 0, 1);
        check_log("t1_w1", 1, 1, 2);
        check_log("t1_w2", 2, 2, 3);
        pulse_reload();

        // 2: bad checksum
        send_word(16'h0002); send_word(16'h1234); send_word(16'h0001); send_word(16'hFFFF);
        cmp("t2_boot_err",  32'(boot_err),  32'd1);
        cmp("t2_cpu_reset", 32'(cpu_reset), 32'd1);
        cmp("t2_rx_ready",  32'(rx_ready),  32'd0);
        pulse_reload();

        // 3: zero-length header
        log_a.delete(); log_d.delete();
        send_word(16'h0000);
        cmp("t3_boot_err", 32'(boot_err), 32'd1);
        repeat (3) @(posedge clock);
        #1;
        cmp("t3_nwrites", 32'(log_a.size()), 32'd0);
        pulse_reload();

        // header one above depth
        send_word(16'(DEPTH + 1));
        cmp("hdr_over_err", 32'(boot_err), 32'd1);
        pulse_reload();

        // 4: stall after three bytes
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        cyc = 0;
        while (!boot_err && cyc < 100) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        cmp("t4_timeout_cycles", 32'(cyc), 32'd16);
        pulse_reload();

        // checksum wraps mod 2^16
        send_word(16'h0002); send_word(16'hFFFF); send_word(16'h0002); send_word(16'h0001);
        cmp("wrap_boot_done", 32'(boot_done), 32'd1);

        // 5: reload from RUN, then reload a one-word image
        pulse_reload();
        cmp("t5_cpu_reset", 32'(cpu_reset), 32'd1);
        cmp("t5_boot_done", 32'(boot_done), 32'd0);
        log_a.delete(); log_d.delete();
        send_word(16'h0001); send_word(16'hABCD); send_word(16'hABCD);
        cmp("t5_rerun", 32'(boot_done), 32'd1);
        check_log("t5_w0", 0, 0, 16'hABCD);

        // reload beats a simultaneous byte
        pulse_reload();
        send_byte(8'h00);
        rx_data = 8'h05; rx_valid = 1'b1; reload = 1'b1;
        @(posedge clock);
        #1;
        rx_valid = 1'b0; reload = 1'b0;
        send_word(16'h0001); send_word(16'h0042); send_word(16'h0042);
        cmp("prio_boot_done", 32'(boot_done), 32'd1);

        // full-depth image: last write lands at DEPTH-1
        pulse_reload();
        log_a.delete(); log_d.delete();
        send_word(16'(DEPTH));
        sum16 = 0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            send_word(16'(i + 1));
            sum16 += i + 1;
        end
        send_word(16'(sum16));
        cmp("full_boot_done", 32'(boot_done), 32'd1);
        cmp("full_nwrites",   32'(log_a.size()), 32'(DEPTH));
        check_log("full_last", int'(DEPTH) - 1, int'(DEPTH) - 1, int'(DEPTH));

        // 6: reset in the middle of DAT_LO
        pulse_reload();
        send_word(16'h0002); send_word(16'h0005); send_byte(8'h00);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        cmp("t6_wr_en",   32'(rom_wr_en),   32'd0);
        cmp("t6_wr_addr", 32'(rom_wr_addr), 32'd0);
        cmp("t6_wr_data", 32'(rom_wr_data), 32'd0);
        cmp("t6_cpu_rst", 32'(cpu_reset),   32'd1);
        cmp("t6_done",    32'(boot_done),   32'd0);
        cmp("t6_err",     32'(boot_err),    32'd0);
        log_a.delete(); log_d.delete();
        send_word(16'h0001); send_word(16'h0007); send_word(16'h0007);
        cmp("t6_boot_done", 32'(boot_done), 32'd1);
        check_log("t6_w0", 0, 0, 7);

        repeat (2) @(posedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
